adc_spi_master: RTL and testbench

ADC_SPI_MASTER -- requirements
Module: adc_spi_master

---
 rtl/adc_spi_master.sv | 178 +++++++++++++++++
 tb/tb_adc_spi_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_master.sv
// SPI master for a serial ADC: 16-bit frame, 3-bit channel address out, DATA_W-bit result in.
// Optional macro ADC_AUTO_SCAN_EN: after one start, scan channels continuously until reset.
module adc_spi_master #(
   parameter int SCK_HALF = 13,
   parameter int DATA_W   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        ch,
   input  logic              adc_dout,
   output logic              adc_cs_n,
   output logic              adc_sck,
   output logic              adc_din,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data,
   output logic [2:0]        data_ch
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   localparam int         SKIP      = 16 - DATA_W;
   localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
   localparam logic [7:0] HALF_FULL = 8'(SCK_HALF);
`ifdef ADC_AUTO_SCAN_EN
   // One cycle shorter so the done-to-done period stays exactly 34*SCK_HALF.
   localparam logic [7:0] HOLD_LAST = 8'(SCK_HALF - 2);
`else
   localparam logic [7:0] HOLD_LAST = 8'(SCK_HALF - 1);
`endif

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [4:0]          half_q, half_d;
   logic [2:0]          ch_q, ch_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [2:0]          data_ch_q, data_ch_d;
   logic                cs_n_q, cs_n_d;
   logic                sck_q, sck_d;
   logic                din_q, din_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   function automatic logic frame_bit(input logic [3:0] k, input logic [2:0] c);
      case (k)
         4'd2:    frame_bit = c[2];
         4'd3:    frame_bit = c[1];
         4'd4:    frame_bit = c[0];
         default: frame_bit = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      ch_d      = ch_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      data_ch_d = data_ch_q;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      din_d     = din_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               ch_d    = ch;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = 8'd0;
               shreg_d = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = 8'd0;
               half_d  = 5'd0;
               sck_d   = 1'b0;
               din_d   = frame_bit(4'd0, ch_q);
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SHIFT: begin
            // Even halves are sck-low, odd halves sck-high; the last high half
            // runs one extra cycle before the frame closes.
            if (half_q == 5'd31) begin
               if (cnt_q == HALF_FULL) begin
                  cnt_d     = 8'd0;
                  cs_n_d    = 1'b1;
                  din_d     = 1'b0;
                  done_d    = 1'b1;
                  data_d    = shreg_q;
                  data_ch_d = ch_q;
                  state_d   = HOLD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else if (cnt_q == HALF_LAST) begin
               cnt_d  = 8'd0;
               half_d = half_q + 5'd1;
               if (!half_q[0]) begin
                  sck_d = 1'b1;
                  if (int'(half_q[4:1]) >= SKIP)
                     shreg_d = {shreg_q[DATA_W-2:0], adc_dout};
               end else begin
                  sck_d = 1'b0;
                  din_d = frame_bit(half_q[4:1] + 4'd1, ch_q);
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = 8'd0;
`ifdef ADC_AUTO_SCAN_EN
               ch_d    = ch_q + 3'd1;
               cs_n_d  = 1'b0;
               state_d = SETUP;
`else
               busy_d  = 1'b0;
               state_d = IDLE;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         half_q    <= 5'd0;
         ch_q      <= 3'd0;
         shreg_q   <= '0;
         data_q    <= '0;
         data_ch_q <= 3'd0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b1;
         din_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         ch_q      <= ch_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         data_ch_q <= data_ch_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign adc_cs_n = cs_n_q;
   assign adc_sck  = sck_q;
   assign adc_din  = din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data     = data_q;
   assign data_ch  = data_ch_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master with SCK_HALF=2: ADC model, frame timing and result checks.
module tb_adc_spi_master;

   localparam int H = 2;
   localparam int DONE_AT = 33*H + 1;
   localparam int BUSY_AT = 34*H + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  ch;
   logic        adc_dout;
   logic        adc_cs_n, adc_sck, adc_din, busy, done;
   logic [11:0] data;
   logic [2:0]  data_ch;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] adc_word;
   logic [15:0] din_cap;
   int          fall_k;
   int          done_cnt = 0;
   int          sck_viol = 0;

   adc_spi_master #(.SCK_HALF(H), .DATA_W(12)) dut (
      .clk(clk), .reset(reset), .start(start), .ch(ch), .adc_dout(adc_dout),
      .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_din(adc_din), .busy(busy),
      .done(done), .data(data), .data_ch(data_ch)
   );

   always #5 clk = ~clk;

   // ADC model: presents the next word bit after every sck falling edge.
   always @(negedge adc_cs_n or negedge adc_sck) begin
      if (adc_sck) begin
         fall_k = 0;
      end else if (!adc_cs_n) begin
         if (fall_k < 16) adc_dout = adc_word[15-fall_k];
         fall_k = fall_k + 1;
      end
   end

   always @(posedge adc_sck) begin
      if (!adc_cs_n && fall_k >= 1 && fall_k <= 16) din_cap[16-fall_k] = adc_din;
   end

   always @(posedge clk) if (done) done_cnt = done_cnt + 1;
   always @(negedge clk) if (adc_cs_n && !adc_sck) sck_viol = sck_viol + 1;

   function automatic logic [15:0] exp_din(input logic [2:0] c);
      exp_din = 16'(c) << 11;
   endfunction

   // Starts one frame and tracks it until busy drops; n counts clk edges after acceptance.
   task automatic do_frame(input logic [2:0] c, input logic [15:0] word,
                           output int t_done, output int t_busy, output int cs_bad);
      adc_word = word;
      @(negedge clk);
      start = 1'b1;
      ch    = c;
      @(posedge clk);
      #1;
      start  = 1'b0;
      ch     = 3'($urandom_range(7));
      t_done = -1;
      t_busy = -1;
      cs_bad = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (done && t_done < 0) t_done = n;
         if (n < DONE_AT && adc_cs_n !== 1'b0) cs_bad++;
         if (!busy) begin
            t_busy = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", adc_cs_n); end
      n_checks++; if (adc_sck !== 1'b1) begin n_fail++; $display("FAIL reset_sck got %b want 1", adc_sck); end
      n_checks++; if (adc_din !== 1'b0) begin n_fail++; $display("FAIL reset_din got %b want 0", adc_din); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
      n_checks++; if (data !== 12'h0 || data_ch !== 3'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", data, data_ch); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int td, tb, cb;
      do_frame(3'd5, 16'h0A5C, td, tb, cb);
      n_checks++; if (din_cap[13:11] !== 3'b101) begin n_fail++; $display("FAIL basic_din_addr got %b want 101", din_cap[13:11]); end
      n_checks++; if (din_cap !== exp_din(3'd5)) begin n_fail++; $display("FAIL basic_din_frame got %h want %h", din_cap, exp_din(3'd5)); end
      n_checks++; if (td != 67) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 67", td); end
      n_checks++; if (data !== 12'hA5C || data_ch !== 3'd5) begin n_fail++; $display("FAIL basic_data got %h/%0d want a5c/5", data, data_ch); end
      n_checks++; if (tb != 69) begin n_fail++; $display("FAIL basic_busy_fall got %0d want 69", tb); end
      n_checks++; if (fall_k != 16) begin n_fail++; $display("FAIL basic_sck_falls got %0d want 16", fall_k); end
      n_checks++; if (cb != 0) begin n_fail++; $display("FAIL basic_cs_low got %0d high cycles want 0", cb); end
   endtask

   task automatic test_random();
      int td, tb, cb;
      logic [2:0]  c;
      logic [15:0] w;
      for (int i = 0; i < 6; i++) begin
         c = 3'($urandom_range(7));
         w = 16'($urandom);
         do_frame(c, w, td, tb, cb);
         n_checks++; if (data !== w[11:0] || data_ch !== c) begin n_fail++; $display("FAIL rand%0d_data got %h/%0d want %h/%0d", i, data, data_ch, w[11:0], c); end
         n_checks++; if (din_cap !== exp_din(c)) begin n_fail++; $display("FAIL rand%0d_din got %h want %h", i, din_cap, exp_din(c)); end
         n_checks++; if (td != DONE_AT || tb != BUSY_AT) begin n_fail++; $display("FAIL rand%0d_timing got %0d/%0d want %0d/%0d", i, td, tb, DONE_AT, BUSY_AT); end
         n_checks++; if (fall_k != 16 || cb != 0) begin n_fail++; $display("FAIL rand%0d_frame got falls %0d cs_bad %0d want 16/0", i, fall_k, cb); end
      end
   endtask

   task automatic test_ignore_start();
      int d0;
      int waited;
      d0 = done_cnt;
      adc_word = 16'h0123;
      @(negedge clk); start = 1'b1; ch = 3'd1;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      start = 1'b1; ch = 3'd3;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (busy && waited < 200) begin @(negedge clk); waited++; end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_timeout busy %b want 0", busy); end
      repeat (100) @(negedge clk);
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", done_cnt - d0); end
      n_checks++; if (data_ch !== 3'd1 || data !== 12'h123) begin n_fail++; $display("FAIL ignore_data got %h/%0d want 123/1", data, data_ch); end
      n_checks++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL ignore_second_frame busy %b cs_n %b want 0/1", busy, adc_cs_n); end
   endtask

   task automatic test_back_to_back();
      int td, tb, cb;
      do_frame(3'd2, 16'hFFFF, td, tb, cb);
      n_checks++; if (data !== 12'hFFF || data_ch !== 3'd2) begin n_fail++; $display("FAIL b2b_first got %h/%0d want fff/2", data, data_ch); end
      do_frame(3'd7, 16'hF000, td, tb, cb);
      n_checks++; if (data !== 12'h000 || data_ch !== 3'd7) begin n_fail++; $display("FAIL b2b_second got %h/%0d want 000/7", data, data_ch); end
      n_checks++; if (td != DONE_AT) begin n_fail++; $display("FAIL b2b_timing got %0d want %0d", td, DONE_AT); end
   endtask

   task automatic test_reset_abort();
      int td, tb, cb, d0, waited;
      logic [15:0] w;
      adc_word = 16'h0FAB;
      @(negedge clk); start = 1'b1; ch = 3'd4;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (fall_k < 9 && waited < 200) begin @(negedge clk); waited++; end
      n_checks++; if (fall_k != 9) begin n_fail++; $display("FAIL abort_reach_bit8 got %0d want 9", fall_k); end
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      n_checks++; if (adc_cs_n !== 1'b1 || adc_sck !== 1'b1) begin n_fail++; $display("FAIL abort_async got cs_n %b sck %b want 1/1", adc_cs_n, adc_sck); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      n_checks++; if (done_cnt != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %0d dones busy %b want 0/0", done_cnt - d0, busy); end
      w = 16'($urandom);
      do_frame(3'd0, w, td, tb, cb);
      n_checks++; if (data !== w[11:0] || data_ch !== 3'd0 || td != DONE_AT) begin n_fail++; $display("FAIL abort_recover got %h/%0d@%0d want %h/0@%0d", data, data_ch, td, w[11:0], DONE_AT); end
   endtask

`ifdef ADC_AUTO_SCAN_EN
   task automatic test_auto_scan();
      int last_t, k;
      logic [2:0] exp_c;
      adc_word = 16'h0321;
      @(negedge clk); start = 1'b1; ch = 3'd6;
      @(negedge clk); start = 1'b0;
      k = 0; last_t = -1; exp_c = 3'd6;
      for (int n = 0; n < 600 && k < 4; n++) begin
         @(negedge clk);
         if (done) begin
            n_checks++; if (data_ch !== exp_c) begin n_fail++; $display("FAIL auto%0d_ch got %0d want %0d", k, data_ch, exp_c); end
            if (last_t >= 0) begin
               n_checks++; if (n - last_t != 34*H) begin n_fail++; $display("FAIL auto%0d_period got %0d want %0d", k, n - last_t, 34*H); end
            end
            last_t = n; exp_c = exp_c + 3'd1; k++;
         end
         if (!busy) begin n_fail++; n_checks++; $display("FAIL auto_busy_drop at %0d want 1", n); end
      end
      n_checks++; if (k != 4) begin n_fail++; $display("FAIL auto_frames got %0d want 4", k); end
   endtask
`endif

   initial begin
      start    = 1'b0;
      ch       = 3'd0;
      adc_dout = 1'b0;
      adc_word = 16'h0;
      din_cap  = 16'h0;
      fall_k   = 0;
      test_reset();
`ifdef ADC_AUTO_SCAN_EN
      test_auto_scan();
`else
      test_basic();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
`endif
      n_checks++; if (sck_viol != 0) begin n_fail++; $display("FAIL sck_idle_high got %0d low cycles with cs_n=1 want 0", sck_viol); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
